// File: rtl/msk_clyde_sbox_col.sv
// Masked 4-bit Clyde S-box for one bitslice column: two layers of PINI AND
// gadgets (inb at t, ina at t+1, out at t+2) sequenced by a small FSM.

module msk_clyde_and_pini2 #(
    parameter int d = 2
) (
    input  logic                   clk,
    input  logic                   i_en,
    input  logic [d-1:0]           i_ina,
    input  logic [d-1:0]           i_inb,
    input  logic [d*(d-1)/2-1:0]   i_rnd,
    output logic [d-1:0]           o_out
);
    logic [d-1:0] w_rm    [d];
    logic [d-1:0] w_terms [d];

    for (genvar gi = 0; gi < d; gi++) begin : g_row
        for (genvar gj = 0; gj < d; gj++) begin : g_col
            logic r_u;
            logic r_r;
            logic r_p;

            // Diagonal carries zero randomness, so the uniform term reduces to a_i & b_i.
            if (gi < gj) begin : g_up
                assign w_rm[gi][gj] = i_rnd[gi*d - gi*(gi+1)/2 + gj - gi - 1];
            end else if (gi > gj) begin : g_lo
                assign w_rm[gi][gj] = i_rnd[gj*d - gj*(gj+1)/2 + gi - gj - 1];
            end else begin : g_diag
                assign w_rm[gi][gj] = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (i_en) begin
                    r_u <= i_inb[gj] ^ w_rm[gi][gj];
                    r_r <= w_rm[gi][gj];
                    r_p <= (~i_ina[gi] & r_r) ^ (i_ina[gi] & r_u);
                end
            end

            assign w_terms[gi][gj] = r_p;
        end

        assign o_out[gi] = ^w_terms[gi];
    end
endmodule

module msk_clyde_sbox_col #(
    parameter int d = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*d-1:0]             in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*(d*(d-1)/2)-1:0]   rnd,
    input  logic                       rnd_valid,
    output logic                       rnd_req,
    output logic [4*d-1:0]             out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int N_RND = d*(d-1)/2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1B,
        S_L1A,
        S_L2B,
        S_L2A,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [4*d-1:0] r_x;
    logic           r_in_ready;
    logic           r_rnd_req;
    logic           r_out_valid;

    logic           w_en1;
    logic           w_en2;
    logic [d-1:0]   w_x0, w_x1, w_x2, w_x3;
    logic [d-1:0]   w_ga, w_gb, w_gc, w_gd;
    logic [d-1:0]   w_y0, w_y1, w_y2, w_y3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_rnd_req   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid && r_in_ready) begin
                    r_x        <= in_data;
                    r_state    <= S_L1B;
                    r_in_ready <= 1'b0;
                    r_rnd_req  <= 1'b1;
                end
                S_L1B: if (rnd_valid) begin
                    r_state   <= S_L1A;
                    r_rnd_req <= 1'b0;
                end
                S_L1A: begin
                    r_state   <= S_L2B;
                    r_rnd_req <= 1'b1;
                end
                S_L2B: if (rnd_valid) begin
                    r_state   <= S_L2A;
                    r_rnd_req <= 1'b0;
                end
                S_L2A: begin
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                end
                S_DONE: if (out_ready) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_rnd_req   <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Enables stay combinational so a stalled L1B/L2B freezes the gadgets in the same cycle.
    assign w_en1 = (r_state == S_L1B && rnd_valid) || (r_state == S_L1A);
    assign w_en2 = (r_state == S_L2B && rnd_valid) || (r_state == S_L2A);

    assign w_x0 = r_x[0*d +: d];
    assign w_x1 = r_x[1*d +: d];
    assign w_x2 = r_x[2*d +: d];
    assign w_x3 = r_x[3*d +: d];

    msk_clyde_and_pini2 #(.d(d)) u_ga (
        .clk(clk), .i_en(w_en1), .i_ina(w_x0), .i_inb(w_x1),
        .i_rnd(rnd[0 +: N_RND]), .o_out(w_ga)
    );
    msk_clyde_and_pini2 #(.d(d)) u_gb (
        .clk(clk), .i_en(w_en1), .i_ina(w_x3), .i_inb(w_x0),
        .i_rnd(rnd[N_RND +: N_RND]), .o_out(w_gb)
    );

    assign w_y1 = w_ga ^ w_x2;
    assign w_y0 = w_gb ^ w_x1;

    msk_clyde_and_pini2 #(.d(d)) u_gc (
        .clk(clk), .i_en(w_en2), .i_ina(w_x3), .i_inb(w_y1),
        .i_rnd(rnd[0 +: N_RND]), .o_out(w_gc)
    );
    msk_clyde_and_pini2 #(.d(d)) u_gd (
        .clk(clk), .i_en(w_en2), .i_ina(w_y1), .i_inb(w_y0),
        .i_rnd(rnd[N_RND +: N_RND]), .o_out(w_gd)
    );

    assign w_y3 = w_gc ^ w_x0;
    assign w_y2 = w_gd ^ w_x3;

    assign out_data  = {w_y3, w_y2, w_y1, w_y0};
    assign in_ready  = r_in_ready;
    assign rnd_req   = r_rnd_req;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_msk_clyde_sbox_col.sv
// Randomized self-checking bench for msk_clyde_sbox_col against the Clyde S-box table.

module tb_msk_clyde_sbox_col;
    localparam int D  = 2;
    localparam int NR = D*(D-1)/2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4*D-1:0]    in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*NR-1:0]   rnd = '0;
    logic              rnd_valid = 1'b0;
    logic              rnd_req;
    logic [4*D-1:0]    out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rnd_used = 0;

    logic [3:0] clyde [16] = '{4'h0, 4'h8, 4'h1, 4'hF, 4'h2, 4'hA, 4'h7, 4'h9,
                               4'h4, 4'hD, 4'h5, 4'h6, 4'hE, 4'h3, 4'hB, 4'hC};

    int         o_lat;
    logic [3:0] o_y;
    int         o_used;
    int         o_acc_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rnd_req && rnd_valid) rnd_used <= rnd_used + 1;
    end

    msk_clyde_sbox_col #(.d(D)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rnd(rnd), .rnd_valid(rnd_valid), .rnd_req(rnd_req),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic logic [4*D-1:0] mask(input logic [3:0] x);
        logic [4*D-1:0] m;
        logic [D-1:0]   s;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            s = D'($urandom);
            s[D-1] = x[i] ^ (^s[D-2:0]);
            m[i*D +: D] = s;
        end
        return m;
    endfunction

    function automatic logic [3:0] unmask(input logic [4*D-1:0] v);
        logic [3:0] y;
        for (int i = 0; i < 4; i++) y[i] = ^v[i*D +: D];
        return y;
    endfunction

    // Runs one operation up to DONE, stalling the first/second rnd request s1/s2 cycles.
    task automatic do_op(input logic [3:0] x, input int s1, input int s2);
        int st1, st2, grants, used0;
        st1 = s1; st2 = s2; grants = 0;
        used0 = rnd_used;
        in_data = mask(x);
        in_valid = 1'b1;
        rnd_valid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = (4*D)'($urandom);
        o_acc_cyc = cyc;
        o_lat = 1;
        while (!out_valid && o_lat < 40) begin
            rnd = (2*NR)'($urandom);
            if (rnd_req) begin
                if (grants == 0 && st1 > 0) begin
                    rnd_valid = 1'b0; st1--;
                end else if (grants == 1 && st2 > 0) begin
                    rnd_valid = 1'b0; st2--;
                end else begin
                    rnd_valid = 1'b1; grants++;
                end
            end else begin
                rnd_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            o_lat++;
        end
        rnd_valid = 1'b0;
        o_y = unmask(out_data);
        o_used = rnd_used - used0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = mask(4'($urandom));
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (rnd_req !== 1'b0) begin n_bad++; $display("FAIL reset_rnd_req got %b want 0", rnd_req); end
    endtask

    task automatic test_basic();
        logic [3:0] xs [2];
        xs[0] = 4'h1; xs[1] = 4'hF;
        for (int k = 0; k < 2; k++) begin
            do_op(xs[k], 0, 0);
            n_cmp++; if (o_lat != 5) begin n_bad++; $display("FAIL basic_latency x=%0h got %0d want 5", xs[k], o_lat); end
            n_cmp++; if (o_y !== clyde[xs[k]]) begin n_bad++; $display("FAIL basic_y x=%0h got %0h want %0h", xs[k], o_y, clyde[xs[k]]); end
            n_cmp++; if (o_used != 2) begin n_bad++; $display("FAIL basic_rnd_used got %0d want 2", o_used); end
            take();
            n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++; $display("FAIL basic_take in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_all_values();
        for (int x = 0; x < 16; x++) begin
            do_op(4'(x), 0, 0);
            n_cmp++; if (o_y !== clyde[x]) begin n_bad++; $display("FAIL table_y x=%0h got %0h want %0h", x, o_y, clyde[x]); end
            take();
        end
    endtask

    task automatic test_rnd_stall();
        logic [3:0] x;
        int s1, s2;
        x = 4'($urandom);
        do_op(x, 3, 2);
        n_cmp++; if (o_lat != 10) begin n_bad++; $display("FAIL stall_latency got %0d want 10", o_lat); end
        n_cmp++; if (o_y !== clyde[x]) begin n_bad++; $display("FAIL stall_y x=%0h got %0h want %0h", x, o_y, clyde[x]); end
        n_cmp++; if (o_used != 2) begin n_bad++; $display("FAIL stall_rnd_used got %0d want 2", o_used); end
        take();
        for (int k = 0; k < 4; k++) begin
            x = 4'($urandom);
            s1 = $urandom_range(0, 4);
            s2 = $urandom_range(0, 4);
            do_op(x, s1, s2);
            n_cmp++; if (o_lat != 5 + s1 + s2) begin n_bad++; $display("FAIL rstall_latency got %0d want %0d", o_lat, 5 + s1 + s2); end
            n_cmp++; if (o_y !== clyde[x]) begin n_bad++; $display("FAIL rstall_y x=%0h got %0h want %0h", x, o_y, clyde[x]); end
            take();
        end
    endtask

    task automatic test_out_backpressure();
        logic [3:0]     x;
        logic [4*D-1:0] held;
        x = 4'($urandom);
        do_op(x, 0, 0);
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data = mask(4'($urandom));
            rnd_valid = 1'($urandom);
            rnd = (2*NR)'($urandom);
            @(posedge clk); #1;
            n_cmp++; if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL hold_cycle%0d out_data=%h in_ready=%b out_valid=%b want %h/0/1", k, out_data, in_ready, out_valid, held);
            end
        end
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        take();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL hold_take in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        x = 4'($urandom);
        do_op(x, 0, 0);
        n_cmp++; if (o_y !== clyde[x] || o_lat != 5) begin
            n_bad++; $display("FAIL hold_next y=%0h lat=%0d want %0h/5", o_y, o_lat, clyde[x]);
        end
        take();
    endtask

    task automatic test_reset_midop();
        logic [3:0] x;
        logic       seen;
        in_data = mask(4'($urandom));
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            rnd = (2*NR)'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rnd_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rnd_req !== 1'b0) begin
            n_bad++; $display("FAIL midrst_state in_ready=%b out_valid=%b rnd_req=%b want 1/0/0", in_ready, out_valid, rnd_req);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_output got out_valid=1 want 0"); end
        x = 4'($urandom);
        do_op(x, 0, 0);
        n_cmp++; if (o_y !== clyde[x] || o_lat != 5) begin
            n_bad++; $display("FAIL midrst_next y=%0h lat=%0d want %0h/5", o_y, o_lat, clyde[x]);
        end
        take();
    endtask

    task automatic test_back_to_back();
        logic [3:0] xa, xb;
        int         acc_a;
        xa = 4'($urandom);
        xb = 4'($urandom);
        do_op(xa, 0, 0);
        acc_a = o_acc_cyc;
        n_cmp++; if (o_y !== clyde[xa]) begin n_bad++; $display("FAIL b2b_ya got %0h want %0h", o_y, clyde[xa]); end
        take();
        do_op(xb, 0, 0);
        n_cmp++; if (o_y !== clyde[xb]) begin n_bad++; $display("FAIL b2b_yb got %0h want %0h", o_y, clyde[xb]); end
        n_cmp++; if (o_acc_cyc - acc_a != 6) begin
            n_bad++; $display("FAIL b2b_period got %0d want 6", o_acc_cyc - acc_a);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_values();
        test_rnd_stall();
        test_out_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
